fetch_queue: RTL

- Parametrised instruction-fetch front end.
- Owns the PC and issues word reads to the instruction memory, which has a fixed latency.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry queue.
- Hands instructions to the decoder over a valid/ready handshake.
- Supports redirect: PC load plus flush of the queue and all in-flight reads. This allows stalls from decode and branch redirects without losing or duplicating instructions.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, the queue entry type and a small valid-bit counting helper
// for the instruction-fetch front end.
package fetch_pkg;
    localparam int          INSTR_W          = 32;
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Number of set bits in an in-flight valid vector (latency is at most 4)
    function automatic logic [2:0] count_valid(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush, occupancy count and simultaneous push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output entry_t                 head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle
    always_comb begin
        pop_ok_s  = pop && (count_r != CNT_W'(0));
        push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
    end

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[tail_r] <= push_data;
                tail_r        <= tail_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    assign head_valid = (count_r != CNT_W'(0));
    assign head_data  = mem_r[head_r];
    assign count      = count_r;
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, fixed-latency in-flight tracking and a decoded-side queue.
// Optional FETCH_QUEUE_PERF_EN adds issued/killed/stall performance counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
    parameter int              DEPTH       = 4,
    parameter int              MEM_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_killed,
    output logic [31:0]        perf_stall,
`endif
    output logic [INSTR_W-1:0] out_instr
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = $clog2(DEPTH + MEM_LATENCY + 1) + 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0]        fetch_pc_r;
    logic [MEM_LATENCY-1:0] infl_valid_r;
    logic [XLEN-1:0]        infl_pc_r [MEM_LATENCY];
    logic [2:0]             infl_cnt_s;
    logic [OCC_W-1:0]       occupancy_s;
    logic                   issue_s;
    logic                   push_s;
    logic                   pop_s;
    logic [CNT_W-1:0]       fifo_count_s;
    logic                   head_valid_s;
    entry_t                 head_s;
    entry_t                 push_entry_s;

    // Issue guard counts in-flight reads as already occupying queue slots
    always_comb begin
        infl_cnt_s  = count_valid(4'(infl_valid_r));
        occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(infl_cnt_s);
        if (reset || redirect_valid) begin
            issue_s = 1'b0;
        end else begin
            issue_s = (occupancy_s < OCC_W'(DEPTH));
        end
    end

    // The oldest in-flight slot meets its response now; a redirect discards it
    always_comb begin
        push_s             = infl_valid_r[MEM_LATENCY-1] && !redirect_valid;
        push_entry_s.pc    = infl_pc_r[MEM_LATENCY-1];
        push_entry_s.instr = imem_rsp_data;
        pop_s              = head_valid_s && out_ready;
    end

    // Fetch PC: redirect target is word aligned, sequential fetch wraps mod 2^XLEN
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(PC_STEP);
        end
    end

    // In-flight shift register: slot 0 takes this cycle's request, slot MEM_LATENCY-1 exits
    always_ff @(posedge clock) begin
        if (reset) begin
            infl_valid_r <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                infl_pc_r[i] <= '0;
            end
        end else if (redirect_valid) begin
            infl_valid_r <= '0;
        end else begin
            infl_valid_r[0] <= issue_s;
            infl_pc_r[0]    <= fetch_pc_r;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                infl_valid_r[i] <= infl_valid_r[i-1];
                infl_pc_r[i]    <= infl_pc_r[i-1];
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_data  (head_s),
        .count      (fifo_count_s)
    );

    assign imem_req_valid = issue_s;
    assign imem_req_addr  = fetch_pc_r;
    assign out_valid      = head_valid_s;
    assign out_pc         = head_s.pc;
    assign out_instr      = head_s.instr;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_issued_r;
    logic [31:0] perf_killed_r;
    logic [31:0] perf_stall_r;

    // Wrapping performance counters; killed counts every valid in-flight slot dropped by a redirect
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issued_r <= 32'd0;
            perf_killed_r <= 32'd0;
            perf_stall_r  <= 32'd0;
        end else begin
            if (issue_s) begin
                perf_issued_r <= perf_issued_r + 32'd1;
            end
            if (redirect_valid) begin
                perf_killed_r <= perf_killed_r + 32'(infl_cnt_s);
            end
            if (head_valid_s && !out_ready) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_r;
    assign perf_killed = perf_killed_r;
    assign perf_stall  = perf_stall_r;
`endif
endmodule
